eth_axi_wr_arb: RTL and testbench
=================================

// Module: eth_axi_wr_arb
// PURPOSE
//  Round-robin arbiter sharing the single AXI4 write path (AW/W/B) of the eth_rgmii MAC slave port
//  between NM requesters (e.g. TX-buffer filler and register/config master).
//  Sequences one single-beat write transaction at a time: grant, address, data, response, release.
//  Sits between the SoC-side masters and the MAC ethernet port; the read path is routed separately.
// PARAMETERS
//  NM  2   number of requesting masters (>=2)
//  AW  32  address width
//  DW  64  data width; strobe width is DW/8
// PORTS
//  clk_i         in   1          system clock
//  rst_i         in   1          asynchronous reset, active high
//  s_aw_valid_i  in   NM         per-master AW valid
//  s_aw_ready_o  out  NM         per-master AW ready
//  s_aw_addr_i   in   NM*AW      per-master address, master i at [i*AW +: AW]
//  s_w_valid_i   in   NM         per-master W valid (WLAST implied, single beat)
//  s_w_ready_o   out  NM         per-master W ready
//  s_w_data_i    in   NM*DW      per-master write data, slice [i*DW +: DW]
//  s_w_strb_i    in   NM*DW/8    per-master strobes, slice [i*DW/8 +: DW/8]
//  s_b_valid_o   out  NM         per-master B valid
//  s_b_ready_i   in   NM         per-master B ready
//  s_b_resp_o    out  2          B response, valid only for the granted master
//  m_aw_valid_o  out  1          AW valid to MAC
//  m_aw_ready_i  in   1          AW ready from MAC
//  m_aw_addr_o   out  AW         AW address to MAC
//  m_w_valid_o   out  1          W valid to MAC (m_w_last implied 1)
//  m_w_ready_i   in   1          W ready from MAC
//  m_w_data_o    out  DW         write data to MAC
//  m_w_strb_o    out  DW/8       strobes to MAC
//  m_b_valid_i   in   1          B valid from MAC
//  m_b_ready_o   out  1          B ready to MAC
//  m_b_resp_i    in   2          B response from MAC
//  gnt_o         out  NM         one-hot current grant (all-zero when idle)
// BEHAVIOUR
//  - FSM: IDLE -> ADDR -> DATA -> RESP -> IDLE. Reset: IDLE, rr_ptr=0, all valid/ready outputs 0,
//    gnt_o=0, m_aw_addr_o/m_w_data_o/m_w_strb_o/s_b_resp_o=0.
//  - IDLE: requests = s_aw_valid_i. First set bit searching upward from rr_ptr (wrapping at NM-1)
//    wins and is registered into gnt_o; ADDR entered next cycle. No request: stay IDLE.
//    W valid alone never requests.
//  - ADDR: m_aw_valid_o=1, m_aw_addr_o = granted slice; s_aw_ready_o[g] = m_aw_ready_i (combinational).
//    On m_aw_valid_o & m_aw_ready_i -> DATA.
//  - DATA: m_w_valid_o = s_w_valid_i[g], data/strb = granted slices; s_w_ready_o[g] = m_w_ready_i.
//    Handshake -> RESP.
//  - RESP: s_b_valid_o[g] = m_b_valid_i, s_b_resp_o = m_b_resp_i (passed through unmodified, incl.
//    SLVERR/DECERR), m_b_ready_o = s_b_ready_i[g]. On B handshake: rr_ptr = (g+1) mod NM, gnt_o=0, -> IDLE.
//  - Non-granted masters: ready/valid outputs held 0 in all states; their requests wait, never lost.
//  - Min latency s_aw_valid -> m_aw_valid: 1 cycle. Back-to-back transactions have 1 IDLE cycle.
//  - Exactly one outstanding transaction; grant cannot change before its B handshake.
//  - Masters must issue AWLEN=0; bursts are unsupported (no W beat counting).
//  - Reset asserted mid-transaction: immediate return to IDLE, all outputs to reset values;
//    the in-flight transaction is abandoned (MAC is reset alongside).
// TESTING
//  - Master0 AW 0x0000_0800, W 0xcafebabe strb 0x0F, MAC B OKAY -> m_aw_addr_o=0x800 one cycle after valid,
//    m_w_data_o=0xcafebabe, m_w_strb_o=0x0F, s_b_valid_o=2'b01 with resp 0, gnt_o back to 0.
//  - Both masters request same cycle after reset -> master0 served first, master1 next (one IDLE cycle
//    between), then with both requesting again master0 again (rr alternation 0,1,0,1).
//  - MAC holds m_aw_ready_i / m_w_ready_i / m_b_valid_i low 5 cycles each -> outputs stable, no duplicate
//    handshake, other master's s_aw_ready_o stays 0 throughout.
//  - Master1 drives W before AW while master0 is in DATA -> s_w_ready_o[1]=0 until master1 granted and in DATA.
//  - MAC returns resp 2'b10 for master1 write -> s_b_resp_o=2'b10 only with s_b_valid_o=2'b10.
//  - rst_i pulsed during DATA -> same edge: m_*_valid_o=0, gnt_o=0; next request granted from rr_ptr=0.

Source files
------------

// File: rtl/eth_axi_wr_arb.sv
// ----------------------------------------------------------------------------
// eth_axi_wr_arb
//   Round-robin arbiter that shares the single AXI4 write path (AW/W/B) of the
//   eth_rgmii MAC slave port between NM requesting masters. One single-beat
//   write is in flight at a time: grant, address, data, response, release.
//   The read path is routed elsewhere.
//
// Ports
//   clk_i, rst_i         clock, asynchronous active-high reset
//   s_aw_*               per-master AW channel (valid/ready/addr slices)
//   s_w_*                per-master W channel (valid/ready/data/strb slices)
//   s_b_*                per-master B channel (valid/ready), shared resp
//   m_aw_*, m_w_*, m_b_* single AXI4 write path towards the MAC
//   gnt_o                one-hot current grant, all-zero when idle
// ----------------------------------------------------------------------------
module eth_axi_wr_arb #(
    parameter int NM = 2,
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NM-1:0]          s_aw_valid_i,
    output logic [NM-1:0]          s_aw_ready_o,
    input  logic [NM*AW-1:0]       s_aw_addr_i,
    input  logic [NM-1:0]          s_w_valid_i,
    output logic [NM-1:0]          s_w_ready_o,
    input  logic [NM*DW-1:0]       s_w_data_i,
    input  logic [NM*(DW/8)-1:0]   s_w_strb_i,
    output logic [NM-1:0]          s_b_valid_o,
    input  logic [NM-1:0]          s_b_ready_i,
    output logic [1:0]             s_b_resp_o,
    output logic                   m_aw_valid_o,
    input  logic                   m_aw_ready_i,
    output logic [AW-1:0]          m_aw_addr_o,
    output logic                   m_w_valid_o,
    input  logic                   m_w_ready_i,
    output logic [DW-1:0]          m_w_data_o,
    output logic [DW/8-1:0]        m_w_strb_o,
    input  logic                   m_b_valid_i,
    output logic                   m_b_ready_o,
    input  logic [1:0]             m_b_resp_i,
    output logic [NM-1:0]          gnt_o
);

    localparam int SW = DW / 8;
    localparam int IW = (NM > 1) ? $clog2(NM) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [NM-1:0] gnt_q, gnt_d;
    logic [IW-1:0] gidx_q, gidx_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;

    logic          arb_found;
    logic [IW-1:0] arb_idx;

    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic [SW-1:0] sel_strb;
    logic          sel_wvalid;
    logic          sel_bready;

    // Round-robin search: first AW request at or above rr_ptr, wrapping.
    always_comb begin
        logic [IW-1:0] cand;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NM; k++) begin
            cand = IW'((32'(rr_ptr_q) + k) % NM);
            if (!arb_found && s_aw_valid_i[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Granted-master slice select as an AND-OR mux over the one-hot grant;
    // with no grant every selected value is zero.
    always_comb begin
        sel_addr   = '0;
        sel_data   = '0;
        sel_strb   = '0;
        sel_wvalid = 1'b0;
        sel_bready = 1'b0;
        for (int unsigned i = 0; i < NM; i++) begin
            if (gnt_q[i]) begin
                sel_addr   = sel_addr | s_aw_addr_i[i*AW +: AW];
                sel_data   = sel_data | s_w_data_i[i*DW +: DW];
                sel_strb   = sel_strb | s_w_strb_i[i*SW +: SW];
                sel_wvalid = sel_wvalid | s_w_valid_i[i];
                sel_bready = sel_bready | s_b_ready_i[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        gidx_d       = gidx_q;
        rr_ptr_d     = rr_ptr_q;
        m_aw_valid_o = 1'b0;
        m_aw_addr_o  = '0;
        s_aw_ready_o = '0;
        m_w_valid_o  = 1'b0;
        m_w_data_o   = '0;
        m_w_strb_o   = '0;
        s_w_ready_o  = '0;
        s_b_valid_o  = '0;
        s_b_resp_o   = '0;
        m_b_ready_o  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    gnt_d   = NM'(1) << arb_idx;
                    gidx_d  = arb_idx;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_aw_valid_o = 1'b1;
                m_aw_addr_o  = sel_addr;
                s_aw_ready_o = gnt_q & {NM{m_aw_ready_i}};
                if (m_aw_ready_i) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                m_w_valid_o = sel_wvalid;
                m_w_data_o  = sel_data;
                m_w_strb_o  = sel_strb;
                s_w_ready_o = gnt_q & {NM{m_w_ready_i}};
                if (sel_wvalid && m_w_ready_i) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                s_b_valid_o = gnt_q & {NM{m_b_valid_i}};
                s_b_resp_o  = m_b_resp_i;
                m_b_ready_o = sel_bready;
                if (m_b_valid_i && sel_bready) begin
                    rr_ptr_d = (gidx_q == IW'(NM - 1)) ? '0 : gidx_q + IW'(1);
                    gnt_d    = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign gnt_o = gnt_q;

endmodule

// File: tb/tb_eth_axi_wr_arb.sv
// ----------------------------------------------------------------------------
// tb_eth_axi_wr_arb
//   Directed bench for eth_axi_wr_arb (NM=2, AW=32, DW=64). A transaction-level
//   model tracks who owns the write path and how far its single write has
//   progressed; every falling edge the DUT outputs are compared with what that
//   ownership implies. Directed scenarios add literal expectations.
// ----------------------------------------------------------------------------
module tb_eth_axi_wr_arb;

    localparam int NM = 2;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NM-1:0]     s_aw_valid_i;
    logic [NM-1:0]     s_aw_ready_o;
    logic [NM*AW-1:0]  s_aw_addr_i;
    logic [NM-1:0]     s_w_valid_i;
    logic [NM-1:0]     s_w_ready_o;
    logic [NM*DW-1:0]  s_w_data_i;
    logic [NM*SW-1:0]  s_w_strb_i;
    logic [NM-1:0]     s_b_valid_o;
    logic [NM-1:0]     s_b_ready_i;
    logic [1:0]        s_b_resp_o;
    logic              m_aw_valid_o;
    logic              m_aw_ready_i;
    logic [AW-1:0]     m_aw_addr_o;
    logic              m_w_valid_o;
    logic              m_w_ready_i;
    logic [DW-1:0]     m_w_data_o;
    logic [SW-1:0]     m_w_strb_o;
    logic              m_b_valid_i;
    logic              m_b_ready_o;
    logic [1:0]        m_b_resp_i;
    logic [NM-1:0]     gnt_o;

    eth_axi_wr_arb #(.NM(NM), .AW(AW), .DW(DW)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .s_aw_valid_i (s_aw_valid_i),
        .s_aw_ready_o (s_aw_ready_o),
        .s_aw_addr_i  (s_aw_addr_i),
        .s_w_valid_i  (s_w_valid_i),
        .s_w_ready_o  (s_w_ready_o),
        .s_w_data_i   (s_w_data_i),
        .s_w_strb_i   (s_w_strb_i),
        .s_b_valid_o  (s_b_valid_o),
        .s_b_ready_i  (s_b_ready_i),
        .s_b_resp_o   (s_b_resp_o),
        .m_aw_valid_o (m_aw_valid_o),
        .m_aw_ready_i (m_aw_ready_i),
        .m_aw_addr_o  (m_aw_addr_o),
        .m_w_valid_o  (m_w_valid_o),
        .m_w_ready_i  (m_w_ready_i),
        .m_w_data_o   (m_w_data_o),
        .m_w_strb_o   (m_w_strb_o),
        .m_b_valid_i  (m_b_valid_i),
        .m_b_ready_o  (m_b_ready_o),
        .m_b_resp_i   (m_b_resp_i),
        .gnt_o        (gnt_o)
    );

    always #5 clk_i = ~clk_i;

    int ncheck = 0;
    int nerr   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncheck++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // owner: master holding the write path (-1 = none)
    // stage: 0 = address pending, 1 = data pending, 2 = response pending
    int m_owner = -1;
    int m_stage = 0;
    int m_ptr   = 0;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_owner = -1;
            m_stage = 0;
            m_ptr   = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NM; k++) begin
                if (m_owner < 0 && s_aw_valid_i[(m_ptr + k) % NM]) begin
                    m_owner = (m_ptr + k) % NM;
                    m_stage = 0;
                end
            end
        end else if (m_stage == 0) begin
            if (m_aw_ready_i) m_stage = 1;
        end else if (m_stage == 1) begin
            if (s_w_valid_i[m_owner] && m_w_ready_i) m_stage = 2;
        end else begin
            if (m_b_valid_i && s_b_ready_i[m_owner]) begin
                m_ptr   = (m_owner + 1) % NM;
                m_owner = -1;
            end
        end
    end

    // ---------------- observation state ----------------
    logic [NM-1:0] f_saw, f_sw, f_sb;
    logic          f_awv, f_awhs, f_wv, f_whs, f_bhs;
    int            cyc = 0;
    logic [NM-1:0] prev_gnt = '0;
    logic [1:0]    q_grant[$];
    int            q_gcyc[$];
    int            q_bcyc[$];
    logic [31:0]   q_addr[$];
    logic [63:0]   q_data[$];
    logic [7:0]    q_strb[$];
    logic [1:0]    q_bval[$];
    logic [1:0]    q_bresp[$];
    int            n_aw_hs, n_w_hs, n_b_hs, n_awv;
    logic          bad_aw_rdy, w1_bad;

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_i) begin
        logic [1:0]  oh;
        logic        in_a, in_w, in_b, e_wv, e_br;
        logic [31:0] e_addr;
        logic [63:0] e_data;
        logic [7:0]  e_strb;
        cyc++;
        oh     = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
        in_a   = (m_owner >= 0) && (m_stage == 0);
        in_w   = (m_owner >= 0) && (m_stage == 1);
        in_b   = (m_owner >= 0) && (m_stage == 2);
        e_addr = '0;
        e_data = '0;
        e_strb = '0;
        e_wv   = 1'b0;
        e_br   = 1'b0;
        if (in_a) e_addr = s_aw_addr_i[m_owner*AW +: AW];
        if (in_w) begin
            e_data = s_w_data_i[m_owner*DW +: DW];
            e_strb = s_w_strb_i[m_owner*SW +: SW];
            e_wv   = s_w_valid_i[m_owner];
        end
        if (in_b) e_br = s_b_ready_i[m_owner];
        chk("gnt_o", gnt_o, oh);
        chk("m_aw_valid_o", m_aw_valid_o, in_a);
        chk("m_aw_addr_o", m_aw_addr_o, e_addr);
        chk("s_aw_ready_o", s_aw_ready_o, (in_a && m_aw_ready_i) ? oh : 2'b00);
        chk("m_w_valid_o", m_w_valid_o, e_wv);
        chk("m_w_data_o", m_w_data_o, e_data);
        chk("m_w_strb_o", m_w_strb_o, e_strb);
        chk("s_w_ready_o", s_w_ready_o, (in_w && m_w_ready_i) ? oh : 2'b00);
        chk("s_b_valid_o", s_b_valid_o, (in_b && m_b_valid_i) ? oh : 2'b00);
        chk("s_b_resp_o", s_b_resp_o, in_b ? m_b_resp_i : 2'b00);
        chk("m_b_ready_o", m_b_ready_o, e_br);

        f_saw  = s_aw_valid_i & s_aw_ready_o;
        f_sw   = s_w_valid_i & s_w_ready_o;
        f_sb   = s_b_valid_o & s_b_ready_i;
        f_awv  = m_aw_valid_o;
        f_awhs = m_aw_valid_o & m_aw_ready_i;
        f_wv   = m_w_valid_o;
        f_whs  = m_w_valid_o & m_w_ready_i;
        f_bhs  = m_b_valid_i & m_b_ready_o;

        if (gnt_o != 2'b00 && prev_gnt == 2'b00) begin
            q_grant.push_back(gnt_o);
            q_gcyc.push_back(cyc);
        end
        prev_gnt = gnt_o;
        if (f_awhs) begin q_addr.push_back(m_aw_addr_o); n_aw_hs++; end
        if (f_whs) begin q_data.push_back(m_w_data_o); q_strb.push_back(m_w_strb_o); n_w_hs++; end
        if (f_bhs) begin
            q_bval.push_back(s_b_valid_o);
            q_bresp.push_back(s_b_resp_o);
            q_bcyc.push_back(cyc);
            n_b_hs++;
        end
        if (m_aw_valid_o) n_awv++;
        if ((s_aw_ready_o & ~gnt_o) != 2'b00) bad_aw_rdy = 1'b1;
        if (s_w_ready_o[1] && !(gnt_o == 2'b10 && m_w_valid_o)) w1_bad = 1'b1;
    end

    // ---------------- stimulus agents ----------------
    int done[NM];
    int aw_delay, w_delay, b_delay;
    int aw_seen, w_seen, b_seen;
    logic b_pend;
    logic [1:0] b_resp_cfg;

    task automatic tick();
        @(posedge clk_i);
        #1;
        for (int i = 0; i < NM; i++) begin
            if (f_saw[i]) s_aw_valid_i[i] = 1'b0;
            if (f_sw[i]) s_w_valid_i[i] = 1'b0;
            if (f_sb[i]) done[i]++;
        end
        if (f_awhs) aw_seen = 0; else if (f_awv) aw_seen++;
        m_aw_ready_i = (aw_seen >= aw_delay);
        if (f_whs) w_seen = 0; else if (f_wv) w_seen++;
        m_w_ready_i = (w_seen >= w_delay);
        if (f_whs) begin b_pend = 1'b1; b_seen = 0; end
        else if (f_bhs) b_pend = 1'b0;
        else if (b_pend) b_seen++;
        m_b_valid_i = b_pend && (b_seen >= b_delay);
        m_b_resp_i  = b_resp_cfg;
    endtask

    task automatic clear_logs();
        q_grant.delete(); q_gcyc.delete(); q_bcyc.delete(); q_addr.delete();
        q_data.delete(); q_strb.delete(); q_bval.delete(); q_bresp.delete();
        n_aw_hs = 0; n_w_hs = 0; n_b_hs = 0; n_awv = 0;
        bad_aw_rdy = 1'b0; w1_bad = 1'b0;
        for (int i = 0; i < NM; i++) done[i] = 0;
    endtask

    task automatic clear_inputs();
        s_aw_valid_i = '0; s_aw_addr_i = '0; s_w_valid_i = '0;
        s_w_data_i = '0; s_w_strb_i = '0; s_b_ready_i = '1;
        m_aw_ready_i = 1'b0; m_w_ready_i = 1'b0; m_b_valid_i = 1'b0; m_b_resp_i = 2'b00;
        aw_seen = 0; w_seen = 0; b_seen = 0; b_pend = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clear_inputs();
        tick();
        tick();
        clear_inputs();
        clear_logs();
        rst_i = 1'b0;
    endtask

    task automatic start_wr(input int i, input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        s_aw_valid_i[i] = 1'b1;
        s_aw_addr_i[i*AW +: AW] = a;
        s_w_valid_i[i] = 1'b1;
        s_w_data_i[i*DW +: DW] = d;
        s_w_strb_i[i*SW +: SW] = s;
    endtask

    task automatic wait_done(input int i, input int n);
        int t;
        t = 0;
        while (done[i] < n && t < 300) begin
            tick();
            t++;
        end
        chk($sformatf("done_m%0d_%0d", i, n), done[i] >= n, 1);
    endtask

    task automatic wait_data();
        int t;
        t = 0;
        while (!f_wv && t < 40) begin
            tick();
            t++;
        end
        chk("reach_data_phase", f_wv, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aw_delay = 0; w_delay = 0; b_delay = 0; b_resp_cfg = 2'b00;
        rst_i = 1'b1;
        clear_inputs();
        clear_logs();
        f_saw = '0; f_sw = '0; f_sb = '0;
        f_awv = 0; f_awhs = 0; f_wv = 0; f_whs = 0; f_bhs = 0;
        tick();
        @(negedge clk_i);
        chk("rst_gnt", gnt_o, 2'b00);
        chk("rst_awv", m_aw_valid_o, 0);
        chk("rst_addr", m_aw_addr_o, 0);
        do_reset();

        // T1: single master0 write
        start_wr(0, 32'h0000_0800, 64'hcafebabe, 8'h0F);
        @(negedge clk_i);
        chk("t1_awv_same_cycle", m_aw_valid_o, 0);
        tick();
        @(negedge clk_i);
        chk("t1_awv_next_cycle", m_aw_valid_o, 1);
        chk("t1_addr", m_aw_addr_o, 32'h800);
        chk("t1_gnt", gnt_o, 2'b01);
        wait_done(0, 1);
        @(negedge clk_i);
        chk("t1_gnt_release", gnt_o, 2'b00);
        chk("t1_log_addr", q_addr[0], 32'h800);
        chk("t1_log_data", q_data[0], 64'hcafebabe);
        chk("t1_log_strb", q_strb[0], 8'h0F);
        chk("t1_log_bval", q_bval[0], 2'b01);
        chk("t1_log_bresp", q_bresp[0], 2'b00);

        // T2: simultaneous requests after reset, round-robin 0,1,0,1
        do_reset();
        start_wr(0, 32'h1000, 64'h1111_2222_3333_4444, 8'hFF);
        start_wr(1, 32'h2000, 64'h5555_6666_7777_8888, 8'hF0);
        wait_done(0, 1);
        start_wr(0, 32'h1008, 64'h0123_4567_89ab_cdef, 8'h01);
        wait_done(1, 1);
        start_wr(1, 32'h2008, 64'hfedc_ba98_7654_3210, 8'h80);
        wait_done(0, 2);
        wait_done(1, 2);
        chk("t2_ngrant", q_grant.size(), 4);
        chk("t2_g0", q_grant[0], 2'b01);
        chk("t2_g1", q_grant[1], 2'b10);
        chk("t2_g2", q_grant[2], 2'b01);
        chk("t2_g3", q_grant[3], 2'b10);
        chk("t2_a1", q_addr[1], 32'h2000);
        chk("t2_a2", q_addr[2], 32'h1008);
        chk("t2_s3", q_strb[3], 8'h80);
        for (int k = 0; k < 3; k++)
            chk($sformatf("t2_idle_gap_%0d", k), q_gcyc[k+1] - q_bcyc[k], 2);

        // T3: MAC stalls 5 cycles on each channel; waiting master sees no ready
        clear_logs();
        aw_delay = 5; w_delay = 5; b_delay = 5;
        start_wr(0, 32'h0000_2100, 64'haaaa_0000_0000_0001, 8'h11);
        start_wr(1, 32'h0000_2200, 64'hbbbb_0000_0000_0002, 8'h22);
        wait_done(0, 1);
        wait_done(1, 1);
        chk("t3_n_aw_hs", n_aw_hs, 2);
        chk("t3_n_w_hs", n_w_hs, 2);
        chk("t3_n_b_hs", n_b_hs, 2);
        chk("t3_aw_valid_cycles", n_awv, 12);
        chk("t3_other_aw_ready", bad_aw_rdy, 0);
        chk("t3_g0", q_grant[0], 2'b01);
        chk("t3_d1", q_data[1], 64'hbbbb_0000_0000_0002);

        // T4: master1 presents W before AW while master0 is in the data phase
        clear_logs();
        aw_delay = 0; w_delay = 4; b_delay = 0;
        start_wr(0, 32'h3000, 64'h0000_0000_3000_0000, 8'h0F);
        wait_data();
        s_w_valid_i[1] = 1'b1;
        s_w_data_i[DW +: DW] = 64'hdead_beef_0000_0001;
        s_w_strb_i[SW +: SW] = 8'h3C;
        tick();
        tick();
        s_aw_valid_i[1] = 1'b1;
        s_aw_addr_i[AW +: AW] = 32'h3100;
        wait_done(0, 1);
        wait_done(1, 1);
        chk("t4_w1_early_ready", w1_bad, 0);
        chk("t4_g1", q_grant[1], 2'b10);
        chk("t4_d1", q_data[1], 64'hdead_beef_0000_0001);
        chk("t4_s1", q_strb[1], 8'h3C);
        chk("t4_a1", q_addr[1], 32'h3100);

        // T5: SLVERR for master1 passed through
        clear_logs();
        w_delay = 0;
        b_resp_cfg = 2'b10;
        start_wr(1, 32'h4000, 64'h4444_4444_4444_4444, 8'hAA);
        wait_done(1, 1);
        chk("t5_bval", q_bval[0], 2'b10);
        chk("t5_bresp", q_bresp[0], 2'b10);
        b_resp_cfg = 2'b00;
        tick();

        // T6: reset during data phase clears outputs and the rr pointer
        clear_logs();
        start_wr(0, 32'h5000, 64'h5000_5000_5000_5000, 8'h55);
        wait_done(0, 1);
        w_delay = 5;
        start_wr(1, 32'h5100, 64'h5100_5100_5100_5100, 8'h66);
        wait_data();
        @(negedge clk_i);
        chk("t6_pre_wv", m_w_valid_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("t6_rst_wv", m_w_valid_o, 0);
        chk("t6_rst_awv", m_aw_valid_o, 0);
        chk("t6_rst_gnt", gnt_o, 2'b00);
        chk("t6_rst_data", m_w_data_o, 64'h0);
        do_reset();
        w_delay = 0;
        start_wr(0, 32'h6000, 64'h6000, 8'h01);
        start_wr(1, 32'h6100, 64'h6100, 8'h02);
        wait_done(0, 1);
        wait_done(1, 1);
        chk("t6_first_after_rst", q_grant[0], 2'b01);
        chk("t6_second_after_rst", q_grant[1], 2'b10);

        tick();
        $display("Result: errors=%0d of %0d checks", nerr, ncheck);
        $finish;
    end

endmodule
